// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: arbiter FSM states, byte width and default sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_e;

    localparam int UART_BYTE_W   = 8;
    localparam int NREQ_DEF      = 4;
    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle around the shared UART TX arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]             req_valid;
    logic [UART_BYTE_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]             req_last;
    logic [NREQ-1:0]             req_ready;
    logic                        tx_start;
    logic [UART_BYTE_W-1:0]      tx_byte;
    logic                        tx_busy;
    logic                        grant_active;
    logic [IDW-1:0]              grant_id;

    // master: the arbiter; slave: requesters plus transmitter
    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_byte, grant_active, grant_id
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_byte, grant_active, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request strictly after 'last', wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    int c;

    // Scan from farthest to nearest so the nearest candidate is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            c = int'(last) + k;
            if (c >= NREQ) c = c - NREQ;
            if (req[c[IDW-1:0]]) begin
                idx = c[IDW-1:0];
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that streams granted requester bytes into one shared UART TX.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int IDW       = 2
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam logic [7:0]     BURST_LIM = 8'(BURST_MAX);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    arb_state_e             state_q, state_d;
    logic [IDW-1:0]         last_q, last_d;
    logic [7:0]             burst_q, burst_d;
    logic                   last_flag_q, last_flag_d;
    logic [IDW-1:0]         gid_q, gid_d;
    logic                   gact_q, gact_d;
    logic [NREQ-1:0]        ready_q, ready_d;
    logic                   start_q, start_d;
    logic [UART_BYTE_W-1:0] byte_q, byte_d;

    logic [UART_BYTE_W-1:0] data_arr [NREQ];
    logic [IDW-1:0]         pick_idx;
    logic                   pick_any;
    logic                   release_grant;

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign data_arr[i] = bus.req_data[UART_BYTE_W*i +: UART_BYTE_W];
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req  (bus.req_valid),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        burst_d       = burst_q;
        last_flag_d   = last_flag_q;
        gid_d         = gid_q;
        gact_d        = gact_q;
        ready_d       = '0;
        start_d       = 1'b0;
        byte_d        = byte_q;
        release_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gid_d   = pick_idx;
                    gact_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (bus.req_valid[gid_q]) begin
                    ready_d     = NREQ'(1) << gid_q;
                    start_d     = 1'b1;
                    byte_d      = data_arr[gid_q];
                    last_flag_d = bus.req_last[gid_q];
                    burst_d     = burst_q + 8'd1;
                    state_d     = WAIT_ACK;
                end else begin
                    release_grant = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_flag_q || burst_q == BURST_LIM || !bus.req_valid[gid_q])
                        release_grant = 1'b1;
                    else
                        state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        // grant_id deliberately survives release so it names the most recent grantee
        if (release_grant) begin
            last_d  = gid_q;
            burst_d = '0;
            gact_d  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= LAST_INIT;
            burst_q     <= '0;
            last_flag_q <= 1'b0;
            gid_q       <= '0;
            gact_q      <= 1'b0;
            ready_q     <= '0;
            start_q     <= 1'b0;
            byte_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            last_flag_q <= last_flag_d;
            gid_q       <= gid_d;
            gact_q      <= gact_d;
            ready_q     <= ready_d;
            start_q     <= start_d;
            byte_q      <= byte_d;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.tx_start     = start_q;
    assign bus.tx_byte      = byte_q;
    assign bus.grant_active = gact_q;
    assign bus.grant_id     = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, busy-timer transmitter, message-level order model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int BURST_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .BURST_MAX(BURST_MAX), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    logic [8:0]     rq [NREQ][$];      // {last, byte} per requester
    logic [31:0]    exp_q [$];         // expected {grant_id, byte} in send order
    int             m_ptr    = NREQ - 1;
    int             bcnt     = 0;
    int             blen_fix = 10;
    int             fall_cyc = -100;
    int             first_start = -1;
    int             phase_t0 = 0;
    int             nstart   = 0;
    logic [IDW-1:0] prev_gid = '0;
    bit             have_prev = 1'b0;
    bit             gact_low  = 1'b1;
    logic [7:0]     held_byte = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        logic [NREQ-1:0]   v;
        logic [NREQ-1:0]   l;
        logic [8*NREQ-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                v[i]        = 1'b1;
                l[i]        = rq[i][0][8];
                d[8*i +: 8] = rq[i][0][7:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.tx_busy   = (bcnt > 0);
    endtask

    // Whole-message view: grantee = next non-empty queue after the pointer; a grant
    // sends until a last byte, BURST_MAX bytes, or the queue runs dry.
    function automatic void predict();
        logic [8:0] mq [NREQ][$];
        logic [8:0] b;
        int         p;
        int         g;
        int         n;
        bit         done;
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        p = m_ptr;
        while (1) begin
            g = -1;
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && mq[(p + k) % NREQ].size() > 0) g = (p + k) % NREQ;
            if (g < 0) break;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                b = mq[g].pop_front();
                exp_q.push_back(32'({IDW'(g), b[7:0]}));
                n++;
                done = b[8] || (n == BURST_MAX) || (mq[g].size() == 0);
            end
            p = g;
        end
        m_ptr = p;
    endfunction

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        if (!bus.grant_active) gact_low = 1'b1;
        if (bus.tx_start) begin
            chk("start_while_busy", 32'(bus.tx_busy), 32'd0);
            chk("ready_onehot", 32'(bus.req_ready), 32'd1 << bus.grant_id);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD0000;
            chk("gid_byte", 32'({bus.grant_id, bus.tx_byte}), e);
            if (have_prev && !gact_low && prev_gid == bus.grant_id)
                chk("b2b_gap", 32'(cyc - fall_cyc), 32'd2);
            if (first_start < 0) first_start = cyc;
            prev_gid  = bus.grant_id;
            have_prev = 1'b1;
            gact_low  = 1'b0;
            held_byte = bus.tx_byte;
            nstart++;
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i] && rq[i].size() > 0) rq[i].delete(0);
            bcnt = (blen_fix > 0) ? blen_fix : int'($urandom_range(1, 12));
        end else begin
            if (bus.req_ready != '0) chk("ready_without_start", 32'(bus.req_ready), 32'd0);
            if (bus.tx_byte != held_byte) chk("byte_hold", 32'(bus.tx_byte), 32'(held_byte));
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) fall_cyc = cyc;
            end
        end
        drive();
    endtask

    function automatic int pending();
        int p;
        p = exp_q.size() + int'(bus.grant_active) + int'(bcnt > 0);
        for (int i = 0; i < NREQ; i++) p += rq[i].size();
        return p;
    endfunction

    task automatic run_phase();
        predict();
        drive();
        phase_t0    = cyc;
        first_start = -1;
        while (cyc - phase_t0 < 4000 && pending() != 0) tick();
        chk("drain", 32'(pending()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bcnt  = 0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        exp_q.delete();
        m_ptr     = NREQ - 1;
        have_prev = 1'b0;
        gact_low  = 1'b1;
        held_byte = 8'h00;
        drive();
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
        chk("rst_grant_active", 32'(bus.grant_active), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int t0;
        drive();
        do_reset();

        // single last byte from requester 0
        rq[0].push_back({1'b1, 8'hA5});
        run_phase();
        chk("lat_valid_to_start", 32'(first_start - phase_t0), 32'd2);
        chk("t1_grant_id", 32'(bus.grant_id), 32'd0);
        chk("t1_grant_active", 32'(bus.grant_active), 32'd0);
        chk("t1_tx_byte", 32'(bus.tx_byte), 32'hA5);

        // simultaneous requesters 0, 1, 3 from a fresh pointer
        do_reset();
        rq[0].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b1, 8'h22});
        rq[3].push_back({1'b1, 8'h33});
        run_phase();
        chk("t2_grant_id", 32'(bus.grant_id), 32'd3);

        // burst cap forces rotation in the middle of a 6-byte message
        rq[1].push_back({1'b1, 8'h5A});
        run_phase();
        blen_fix = 0;
        for (int b = 1; b <= 6; b++) rq[2].push_back({(b == 6), 8'(b)});
        rq[1].push_back({1'b1, 8'h77});
        run_phase();
        chk("t3_grant_id", 32'(bus.grant_id), 32'd2);

        // requester 3 drops valid after two bytes without last
        rq[3].push_back({1'b0, 8'hC1});
        rq[3].push_back({1'b0, 8'hC2});
        rq[0].push_back({1'b1, 8'hD1});
        run_phase();
        chk("t4_grant_id", 32'(bus.grant_id), 32'd0);

        // reset while the transmitter is mid-frame
        blen_fix = 10;
        rq[2].push_back({1'b1, 8'h7E});
        predict();
        drive();
        t0 = cyc;
        while (nstart == 0 || cyc - t0 < 2) begin
            if (cyc - t0 > 50) break;
            tick();
        end
        chk("t5_started", 32'(nstart > 0), 32'd1);
        repeat (4) tick();
        chk("t5_busy_before_reset", 32'(bus.tx_busy), 32'd1);
        do_reset();
        rq[2].push_back({1'b1, 8'hE2});
        rq[0].push_back({1'b1, 8'hE0});
        run_phase();
        chk("t5_grant_id", 32'(bus.grant_id), 32'd2);

        // randomized message mixes
        blen_fix = 0;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int nm;
                nm = int'($urandom_range(0, 2));
                for (int m = 0; m < nm; m++) begin
                    int  len;
                    bit  drop;
                    len  = int'($urandom_range(1, 6));
                    drop = (m == nm - 1) && ($urandom_range(0, 3) == 0);
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1) && !drop, 8'($urandom)});
                end
            end
            run_phase();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte-stream requesters.
- Grants one requester at a time and holds the grant for a whole message, capped at BURST_MAX bytes.
- Moves each byte into the transmitter with a start/busy handshake.
- Sits between the protocol/status sources and the single shared serial TX path that mirrors the receiver top.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BURST_MAX, 4, max bytes sent per grant before forced rotation (1..255).
- IDW, 2, width of grant_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester byte available.
- req_data  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- req_last  in  NREQ  byte on req_data is the final byte of the message.
- req_ready  out  NREQ  one-hot one-cycle accept pulse to the granted requester.
- tx_start  out  1  one-cycle pulse: transmitter loads tx_byte.
- tx_byte  out  8  byte for the transmitter; registered, stable from the tx_start cycle until the next load.
- tx_busy  in  1  transmitter frame in progress (start, data and stop bits).
- grant_active  out  1  a grant is held.
- grant_id  out  IDW  index of the current or most recent grantee.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, tx_start=0, tx_byte=8'h00, grant_active=0, grant_id=0.
  - Internal: state=IDLE, last pointer=NREQ-1 so requester 0 has first priority, burst count=0.
- Requester rule: once req_valid[i] rises, it and the byte stay stable until req_ready[i].
- State IDLE:
  - If any req_valid is high, pick the first set bit searching from last+1 upward with wrap mod NREQ.
  - Register grant_id, set grant_active=1, go to LOAD.
  - No valid: stay in IDLE.
- State LOAD (exactly 1 cycle):
  - If req_valid[g]=1: pulse req_ready[g] and tx_start, register tx_byte=req_data[g], latch last_flag=req_last[g], increment burst count, go to WAIT_ACK.
  - If req_valid[g]=0: treat as release (see below).
- State WAIT_ACK: stay until tx_busy=1, then go to WAIT_DONE. There is no timeout; the transmitter is required to raise busy within 1 cycle of tx_start.
- State WAIT_DONE: stay until tx_busy=0. Then:
  - Release if last_flag=1, or burst count==BURST_MAX, or req_valid[g]=0.
  - Otherwise return to LOAD with the same grant.
- Release:
  - last pointer <= g, burst count <= 0, grant_active <= 0, go to IDLE.
  - grant_id keeps its value.
  - Arbitration resumes on the next cycle, so there is a 1-cycle IDLE gap between grants.
- Latency:
  - Valid seen in IDLE to req_ready/tx_start: 2 cycles.
  - Busy falling to the next tx_start within the same grant: 2 cycles.
- Simultaneous requests: strict round-robin order; no requester is granted twice while another waits.
- A request arriving during a grant waits for release; no pre-emption.
- req_last together with burst count==BURST_MAX: a single release; the pointer advances once.
- tx_busy high in IDLE or LOAD is ignored. LOAD issues tx_start regardless; the caller guarantees idle.
- Burst counter is 8 bits and never wraps, because release occurs at BURST_MAX.
- Reset mid-frame:
  - All state clears immediately (asynchronous reset).
  - A partially sent byte is abandoned; the transmitter is reset by the same rst_n.
- Only one bit of req_ready is ever high. tx_start and req_ready are asserted in the same cycle.

Decomposition:
- Shared package uart_pkg holds:
  - The state enum: IDLE, LOAD, WAIT_ACK, WAIT_DONE.
  - UART_BYTE_W=8.
  - The default NREQ and BURST_MAX constants.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority encoder with inputs req vector and last pointer, outputs index and any.
  - Reused by future arbiters.
- Everything else lives in uart_tx_arbiter.

Test Plan:
- Reset release, requester 0 sends a single byte 0xA5 with last=1, transmitter model busy for 10 cycles → req_ready[0] and tx_start 2 cycles after valid, tx_byte=0xA5, grant released after busy falls, grant_id=0.
- Requesters 0, 1 and 3 assert simultaneously, one last byte each (0x11, 0x22, 0x33) → tx_byte order 0x11, 0x22, 0x33; grant_id sequence 0, 1, 3.
- Requester 2 sends a 6-byte message 0x01..0x06 with last on 0x06 and BURST_MAX=4, requester 1 also waiting → bytes 0x01..0x04, then requester 1's byte, then 0x05, 0x06.
- Requester drops req_valid after 2 bytes without last → release after the second busy falls, grant_active=0, next requester served.
- rst_n asserted during WAIT_DONE of byte 0x7E → all outputs at reset values immediately; after release requester 0 has priority again.
- Back-to-back bytes within one grant → exactly 2 cycles from busy falling to the next tx_start; tx_start is never issued while tx_busy=1 in the WAIT states.
